// File: rtl/data_memory_responder.sv
// Multi-channel valid/ready data-memory responder with a shared RAM.
// Every channel runs its own fixed-latency FSM; a side port preloads the RAM.
module data_memory_responder #(
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int LATENCY      = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CHANNELS-1:0]           read_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] read_address,
    output logic [NUM_CHANNELS-1:0]           read_ready,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] read_data,
    input  logic [NUM_CHANNELS-1:0]           write_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] write_address,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] write_data,
    output logic [NUM_CHANNELS-1:0]           write_ready,
    input  logic                              load_en,
    input  logic [ADDR_BITS-1:0]              load_addr,
    input  logic [DATA_BITS-1:0]              load_data
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    logic [DATA_BITS-1:0]              mem [DEPTH];
    logic [NUM_CHANNELS-1:0]           wr_commit;
    logic [NUM_CHANNELS*ADDR_BITS-1:0] ch_addr;
    logic [NUM_CHANNELS*DATA_BITS-1:0] ch_wdata;

    // Later loop iterations override earlier ones: highest channel wins, load loses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem[a] <= '0;
            end
        end else begin
            if (load_en) begin
                mem[load_addr] <= load_data;
            end
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (wr_commit[i]) begin
                    mem[ch_addr[i*ADDR_BITS +: ADDR_BITS]] <=
                        ch_wdata[i*DATA_BITS +: DATA_BITS];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        state_t               state_q, state_d;
        logic [3:0]           cnt_q, cnt_d;
        logic                 op_q, op_d;
        logic [ADDR_BITS-1:0] addr_q, addr_d;
        logic [DATA_BITS-1:0] wdata_q, wdata_d;
        logic                 rdy_q, rdy_d;
        logic [DATA_BITS-1:0] rdata_q;
        logic                 commit;
        logic                 op_valid;

        // op_q = 1 marks a latched write
        assign op_valid = op_q ? write_valid[g] : read_valid[g];

        always_ff @(posedge clk) begin
            if (!reset) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                op_q    <= 1'b0;
                addr_q  <= '0;
                wdata_q <= '0;
                rdy_q   <= 1'b0;
                rdata_q <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                op_q    <= op_d;
                addr_q  <= addr_d;
                wdata_q <= wdata_d;
                rdy_q   <= rdy_d;
                if (commit && !op_q) begin
                    rdata_q <= mem[addr_q];
                end
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            op_d    = op_q;
            addr_d  = addr_q;
            wdata_d = wdata_q;
            rdy_d   = rdy_q;
            commit  = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (write_valid[g] || read_valid[g]) begin
                        op_d    = write_valid[g];
                        addr_d  = write_valid[g]
                                ? write_address[g*ADDR_BITS +: ADDR_BITS]
                                : read_address[g*ADDR_BITS +: ADDR_BITS];
                        wdata_d = write_data[g*DATA_BITS +: DATA_BITS];
                        cnt_d   = CNT_INIT;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        commit  = 1'b1;
                        rdy_d   = 1'b1;
                        state_d = RESP;
                    end
                end
                RESP: begin
                    if (!op_valid) begin
                        rdy_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        assign read_ready[g]  = rdy_q & ~op_q;
        assign write_ready[g] = rdy_q & op_q;
        assign wr_commit[g]   = commit & op_q;
        assign read_data[g*DATA_BITS +: DATA_BITS] = rdata_q;
        assign ch_addr[g*ADDR_BITS +: ADDR_BITS]   = addr_q;
        assign ch_wdata[g*DATA_BITS +: DATA_BITS]  = wdata_q;
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: transaction-level memory model,
// random multi-channel traffic plus directed protocol and reset scenarios.
module tb_data_memory_responder;

    localparam int NC  = 4;
    localparam int AB  = 8;
    localparam int DB  = 8;
    localparam int LAT = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NC-1:0]    read_valid = '0;
    logic [NC*AB-1:0] read_address = '0;
    logic [NC-1:0]    read_ready;
    logic [NC*DB-1:0] read_data;
    logic [NC-1:0]    write_valid = '0;
    logic [NC*AB-1:0] write_address = '0;
    logic [NC*DB-1:0] write_data = '0;
    logic [NC-1:0]    write_ready;
    logic             load_en = 1'b0;
    logic [AB-1:0]    load_addr = '0;
    logic [DB-1:0]    load_data = '0;

    data_memory_responder #(
        .NUM_CHANNELS(NC), .ADDR_BITS(AB), .DATA_BITS(DB), .LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .read_valid(read_valid), .read_address(read_address),
        .read_ready(read_ready), .read_data(read_data),
        .write_valid(write_valid), .write_address(write_address),
        .write_data(write_data), .write_ready(write_ready),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         fall;
        int         ch;
        bit         wr;
        bit         ld;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        int         rise;
        int         fall;
        bit         wr;
        logic [7:0] data;
    } exp_t;

    ev_t        pend[$];
    ev_t        keep[$];
    exp_t       exp_q[NC][$];
    exp_t       cur[NC];
    exp_t       e_x;
    logic [7:0] mem_m [256];
    logic [NC-1:0] prev_r = '0;
    logic [NC-1:0] prev_w = '0;

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input int act, input int req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    function automatic ev_t mk(input int c, input int f, input int ch,
                               input bit wr, input bit ld,
                               input logic [7:0] addr,
                               input logic [7:0] data);
        ev_t e;
        e.cyc = c; e.fall = f; e.ch = ch; e.wr = wr; e.ld = ld;
        e.addr = addr; e.data = data;
        return e;
    endfunction

    // Reference model: at edge c, reads see memory before edge c's writes;
    // loads apply first, then channel writes in ascending index order.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            foreach (mem_m[k]) mem_m[k] = 8'h00;
            pend.delete();
            for (int c = 0; c < NC; c++) exp_q[c].delete();
        end else begin
            foreach (pend[k]) begin
                if (pend[k].cyc == cyc && !pend[k].ld && !pend[k].wr) begin
                    e_x.rise = cyc; e_x.fall = pend[k].fall;
                    e_x.wr = 1'b0; e_x.data = mem_m[pend[k].addr];
                    exp_q[pend[k].ch].push_back(e_x);
                end
            end
            foreach (pend[k]) begin
                if (pend[k].cyc == cyc && pend[k].ld)
                    mem_m[pend[k].addr] = pend[k].data;
            end
            for (int c = 0; c < NC; c++) begin
                foreach (pend[k]) begin
                    if (pend[k].cyc == cyc && pend[k].wr && pend[k].ch == c) begin
                        mem_m[pend[k].addr] = pend[k].data;
                        e_x.rise = cyc; e_x.fall = pend[k].fall;
                        e_x.wr = 1'b1; e_x.data = pend[k].data;
                        exp_q[c].push_back(e_x);
                    end
                end
            end
            keep.delete();
            foreach (pend[k]) if (pend[k].cyc != cyc) keep.push_back(pend[k]);
            pend = keep;
        end
    end

    // Monitor: pops an expectation on every ready rise, checks fall timing.
    always @(negedge clk) begin
        if (reset) begin
            for (int c = 0; c < NC; c++) begin
                if ((read_ready[c] || write_ready[c]) && !(prev_r[c] || prev_w[c])) begin
                    if (exp_q[c].size() == 0) begin
                        chk($sformatf("unexpected_ready_ch%0d", c), 1, 0);
                    end else begin
                        cur[c] = exp_q[c].pop_front();
                        chk($sformatf("rise_cycle_ch%0d", c), cyc, cur[c].rise);
                        chk($sformatf("op_kind_ch%0d", c),
                            int'(write_ready[c]), int'(cur[c].wr));
                        if (!cur[c].wr)
                            chk($sformatf("read_data_ch%0d", c),
                                int'(read_data[c*DB +: DB]), int'(cur[c].data));
                    end
                end else if (!(read_ready[c] || write_ready[c]) &&
                             (prev_r[c] || prev_w[c])) begin
                    chk($sformatf("fall_cycle_ch%0d", c), cyc, cur[c].fall);
                end
                prev_r[c] = read_ready[c];
                prev_w[c] = write_ready[c];
            end
        end else begin
            prev_r = '0;
            prev_w = '0;
        end
    end

    // Called at a negedge; valid is sampled high on the next k edges.
    task automatic issue(input int ch, input bit wr, input logic [7:0] addr,
                         input logic [7:0] data, input int k);
        int a, r, f;
        a = cyc + 1;
        r = a + LAT;
        f = (a + k > r + 1) ? a + k : r + 1;
        if (wr) begin
            write_valid[ch] = 1'b1;
            write_address[ch*AB +: AB] = addr;
            write_data[ch*DB +: DB] = data;
        end else begin
            read_valid[ch] = 1'b1;
            read_address[ch*AB +: AB] = addr;
        end
        pend.push_back(mk(r, f, ch, wr, 1'b0, addr, data));
        @(negedge clk);
        write_address[ch*AB +: AB] = 8'($urandom);
        write_data[ch*DB +: DB] = 8'($urandom);
        read_address[ch*AB +: AB] = 8'($urandom);
        repeat (k - 1) @(negedge clk);
        write_valid[ch] = 1'b0;
        read_valid[ch] = 1'b0;
        while (cyc < f) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] addr, input logic [7:0] data);
        load_en = 1'b1;
        load_addr = addr;
        load_data = data;
        pend.push_back(mk(cyc + 1, 0, 0, 1'b0, 1'b1, addr, data));
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Write and read both requested: write first, read accepted after it.
    task automatic both_valid(input int ch, input logic [7:0] addr,
                              input logic [7:0] data);
        int a, r, r2;
        a = cyc + 1;
        r = a + LAT;
        r2 = r + 2 + LAT;
        write_valid[ch] = 1'b1;
        read_valid[ch] = 1'b1;
        write_address[ch*AB +: AB] = addr;
        read_address[ch*AB +: AB] = addr;
        write_data[ch*DB +: DB] = data;
        pend.push_back(mk(r, r + 1, ch, 1'b1, 1'b0, addr, data));
        pend.push_back(mk(r2, r2 + 1, ch, 1'b0, 1'b0, addr, 8'h00));
        @(negedge clk);
        write_valid[ch] = 1'b0;
        while (cyc < r2) @(negedge clk);
        read_valid[ch] = 1'b0;
        while (cyc < r2 + 1) @(negedge clk);
    endtask

    task automatic rand_chan(input int ch, input int n);
        logic [7:0] addr;
        repeat (n) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            addr = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7))
                                               : 8'($urandom);
            issue(ch, 1'($urandom_range(0, 1)), addr, 8'($urandom),
                  int'($urandom_range(1, 5)));
        end
    endtask

    task automatic rand_load(input int n);
        repeat (n) begin
            if ($urandom_range(0, 3) == 0)
                do_load(8'($urandom_range(0, 7)), 8'($urandom));
            else
                @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_read_ready", int'(read_ready), 0);
        chk("reset_write_ready", int'(write_ready), 0);
        chk("reset_read_data", int'(read_data), 0);
        reset = 1'b1;
        @(negedge clk);

        do_load(8'h10, 8'hA5);
        issue(0, 1'b0, 8'h10, 8'h00, 1);

        issue(1, 1'b1, 8'h20, 8'h3C, 1);
        issue(1, 1'b0, 8'h20, 8'h00, 1);

        fork
            issue(0, 1'b1, 8'h40, 8'h11, 1);
            issue(3, 1'b1, 8'h40, 8'h33, 1);
            begin
                repeat (LAT) @(negedge clk);
                do_load(8'h40, 8'hEE);
            end
        join
        issue(1, 1'b0, 8'h40, 8'h00, 1);

        for (int i = 0; i < NC; i++) do_load(8'(8'h80 + i), 8'(8'hC0 + i));
        fork
            issue(0, 1'b0, 8'h80, 8'h00, 1);
            issue(1, 1'b0, 8'h81, 8'h00, 1);
            issue(2, 1'b0, 8'h82, 8'h00, 1);
            issue(3, 1'b0, 8'h83, 8'h00, 1);
        join

        issue(2, 1'b0, 8'h10, 8'h00, LAT + 6);
        issue(2, 1'b0, 8'h20, 8'h00, 1);

        both_valid(0, 8'h30, 8'h5A);

        fork
            rand_chan(0, 30);
            rand_chan(1, 30);
            rand_chan(2, 30);
            rand_chan(3, 30);
            rand_load(150);
        join
        repeat (10) @(negedge clk);
        chk("pending_drained", pend.size(), 0);
        for (int c = 0; c < NC; c++)
            chk($sformatf("scoreboard_empty_ch%0d", c), exp_q[c].size(), 0);

        do_load(8'h50, 8'h77);
        issue(1, 1'b0, 8'h50, 8'h00, 1);
        fork
            issue(0, 1'b1, 8'h50, 8'h99, 1);
            begin
                @(negedge clk);
                reset = 1'b0;
                do_load(8'h60, 8'h12);
                reset = 1'b1;
            end
        join
        repeat (3) begin
            chk("post_reset_write_ready", int'(write_ready), 0);
            chk("post_reset_read_ready", int'(read_ready), 0);
            @(negedge clk);
        end
        issue(1, 1'b0, 8'h50, 8'h00, 1);
        issue(2, 1'b0, 8'h60, 8'h00, 1);
        issue(3, 1'b0, 8'h10, 8'h00, 1);
        repeat (5) @(negedge clk);
        chk("final_pending_drained", pend.size(), 0);
        for (int c = 0; c < NC; c++)
            chk($sformatf("final_scoreboard_empty_ch%0d", c), exp_q[c].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
